execute: RTL and testbench

// - Execute stage of the 5-stage MIPS pipeline.
// - Computes ALU results and runs an iterative multiply/divide unit that owns the HI/LO registers.
// - Stalls the E stage on HI/LO hazards.
// - Registers the E->M pipeline register that feeds the memory stage.

---
 rtl/pipeline_pkg.sv | 20 ++
 rtl/muldiv_unit.sv | 108 ++++++++++
 rtl/execute.sv | 92 +++++++++
 tb/tb_execute.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared types and helpers for the MIPS execute stage.
package pipeline_pkg;

    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI, ALU_MFHI, ALU_MFLO,
        ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU, ALU_MTHI, ALU_MTLO
    } alu_op_t;

    typedef enum logic [1:0] {IDLE, BUSY, FIN} muldiv_state_t;

    function automatic logic is_muldiv_op(input alu_op_t op);
        return op inside {ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU};
    endfunction

    function automatic logic is_hilo_op(input alu_op_t op);
        return is_muldiv_op(op) || (op inside {ALU_MFHI, ALU_MFLO, ALU_MTHI, ALU_MTLO});
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide owning HI/LO.
// Works on operand magnitudes; signs are reapplied in the FIN cycle.
module muldiv_unit
    import pipeline_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  alu_op_t          op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             hi_we_i,
    input  logic             lo_we_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             busy_o
);

    localparam int CW = $clog2(WIDTH);

    muldiv_state_t      r_state, w_next;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_p;
    logic [WIDTH-1:0]   r_b, r_hi, r_lo;
    logic               r_div, r_neg_q, r_neg_r, r_div0;
    logic               w_signed, w_div, w_launch;
    logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_q, w_r, w_hi, w_lo;
    logic [WIDTH:0]     w_sum, w_rem, w_diff;
    logic [2*WIDTH-1:0] w_step, w_prod;

    assign w_signed = op_i inside {ALU_MULT, ALU_DIV};
    assign w_div    = op_i inside {ALU_DIV, ALU_DIVU};
    assign w_launch = start_i && (r_state == IDLE);
    assign w_abs_a  = (w_signed && a_i[WIDTH-1]) ? -a_i : a_i;
    assign w_abs_b  = (w_signed && b_i[WIDTH-1]) ? -b_i : b_i;

    // Multiply: r_p = {partial product, remaining multiplier}, shifted right each step.
    assign w_sum  = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_b} : '0);
    // Divide: r_p = {remainder, remaining dividend/quotient}, shifted left each step.
    assign w_rem  = r_p[2*WIDTH-1:WIDTH-1];
    assign w_diff = w_rem - {1'b0, r_b};
    assign w_step = !r_div     ? {w_sum, r_p[WIDTH-1:1]} :
                    w_diff[WIDTH] ? {w_rem[WIDTH-1:0], r_p[WIDTH-2:0], 1'b0} :
                                    {w_diff[WIDTH-1:0], r_p[WIDTH-2:0], 1'b1};

    assign w_prod = r_neg_q ? -r_p : r_p;
    assign w_q    = r_neg_q ? -r_p[WIDTH-1:0] : r_p[WIDTH-1:0];
    assign w_r    = r_neg_r ? -r_p[2*WIDTH-1:WIDTH] : r_p[2*WIDTH-1:WIDTH];
    assign w_hi   = r_div ? w_r : w_prod[2*WIDTH-1:WIDTH];
    assign w_lo   = r_div ? (r_div0 ? '1 : w_q) : w_prod[WIDTH-1:0];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = (r_state == IDLE) ? (start_i ? BUSY : IDLE) :
                 (r_state == BUSY) ? (&r_cnt ? FIN : BUSY) : IDLE;
    end

    always_comb begin
        busy_o = (r_state != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt   <= '0;
            r_p     <= '0;
            r_b     <= '0;
            r_div   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_div0  <= 1'b0;
        end else if (w_launch) begin
            r_cnt   <= '0;
            r_p     <= {{WIDTH{1'b0}}, w_abs_a};
            r_b     <= w_abs_b;
            r_div   <= w_div;
            r_neg_q <= w_signed && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            r_neg_r <= w_signed && a_i[WIDTH-1];
            r_div0  <= w_div && (b_i == '0);
        end else if (r_state == BUSY) begin
            r_cnt <= r_cnt + 1'b1;
            r_p   <= w_step;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (r_state == FIN) begin
            r_hi <= w_hi;
            r_lo <= w_lo;
        end else if (r_state == IDLE) begin
            if (hi_we_i) r_hi <= wdata_i;
            if (lo_we_i) r_lo <= wdata_i;
        end
    end

    assign hi_o = r_hi;
    assign lo_o = r_lo;

endmodule

// File: rtl/execute.sv
// execute: MIPS E stage -- ALU, mul/div unit, HI/LO hazard stall and E->M register.
module execute
    import pipeline_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             reg_write_e_i,
    input  logic             mem_to_reg_e_i,
    input  logic             mem_write_e_i,
    input  alu_op_t          alu_control_e_i,
    input  logic [WIDTH-1:0] src_a_e_i,
    input  logic [WIDTH-1:0] src_b_e_i,
    input  logic [4:0]       shamt_e_i,
    input  logic [WIDTH-1:0] write_data_e_i,
    input  logic [4:0]       write_reg_e_i,
    output logic             stall_e_o,
    output logic             reg_write_m_o,
    output logic             mem_to_reg_m_o,
    output logic             mem_write_m_o,
    output logic [WIDTH-1:0] alu_out_m_o,
    output logic [WIDTH-1:0] write_data_m_o,
    output logic [4:0]       write_reg_m_o
);

    logic [WIDTH-1:0] w_hi, w_lo, w_alu;
    logic             w_busy, w_start, w_hi_we, w_lo_we;

    assign stall_e_o = w_busy && is_hilo_op(alu_control_e_i);
    assign w_start   = !w_busy && is_muldiv_op(alu_control_e_i);
    assign w_hi_we   = !w_busy && (alu_control_e_i == ALU_MTHI);
    assign w_lo_we   = !w_busy && (alu_control_e_i == ALU_MTLO);

    muldiv_unit #(.WIDTH(WIDTH)) u_md (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (w_start),
        .op_i    (alu_control_e_i),
        .a_i     (src_a_e_i),
        .b_i     (src_b_e_i),
        .hi_we_i (w_hi_we),
        .lo_we_i (w_lo_we),
        .wdata_i (src_a_e_i),
        .hi_o    (w_hi),
        .lo_o    (w_lo),
        .busy_o  (w_busy)
    );

    always_comb begin
        w_alu = '0;
        case (alu_control_e_i)
            ALU_ADD:  w_alu = src_a_e_i + src_b_e_i;
            ALU_SUB:  w_alu = src_a_e_i - src_b_e_i;
            ALU_AND:  w_alu = src_a_e_i & src_b_e_i;
            ALU_OR:   w_alu = src_a_e_i | src_b_e_i;
            ALU_XOR:  w_alu = src_a_e_i ^ src_b_e_i;
            ALU_NOR:  w_alu = ~(src_a_e_i | src_b_e_i);
            ALU_SLT:  w_alu = {{(WIDTH-1){1'b0}}, $signed(src_a_e_i) < $signed(src_b_e_i)};
            ALU_SLTU: w_alu = {{(WIDTH-1){1'b0}}, src_a_e_i < src_b_e_i};
            ALU_SLL:  w_alu = src_b_e_i << shamt_e_i;
            ALU_SRL:  w_alu = src_b_e_i >> shamt_e_i;
            ALU_SRA:  w_alu = $signed(src_b_e_i) >>> shamt_e_i;
            ALU_LUI:  w_alu = {src_b_e_i[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            ALU_MFHI: w_alu = w_hi;
            ALU_MFLO: w_alu = w_lo;
            default:  w_alu = '0;
        endcase
    end

    // A stalled cycle sends a bubble: control cleared, data fields left as they were.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            reg_write_m_o  <= 1'b0;
            mem_to_reg_m_o <= 1'b0;
            mem_write_m_o  <= 1'b0;
            alu_out_m_o    <= '0;
            write_data_m_o <= '0;
            write_reg_m_o  <= '0;
        end else begin
            reg_write_m_o  <= reg_write_e_i && !stall_e_o;
            mem_to_reg_m_o <= mem_to_reg_e_i && !stall_e_o;
            mem_write_m_o  <= mem_write_e_i && !stall_e_o;
            if (!stall_e_o) begin
                alu_out_m_o    <= w_alu;
                write_data_m_o <= write_data_e_i;
                write_reg_m_o  <= write_reg_e_i;
            end
        end
    end

endmodule

// File: tb/tb_execute.sv
// tb_execute: scoreboard bench for the execute stage.
module tb_execute;
    import pipeline_pkg::*;

    logic        clk_i = 1'b0, rst_i = 1'b0;
    logic        reg_write_e_i, mem_to_reg_e_i, mem_write_e_i;
    alu_op_t     alu_control_e_i;
    logic [31:0] src_a_e_i, src_b_e_i, write_data_e_i;
    logic [4:0]  shamt_e_i, write_reg_e_i;
    logic        stall_e_o, reg_write_m_o, mem_to_reg_m_o, mem_write_m_o;
    logic [31:0] alu_out_m_o, write_data_m_o;
    logic [4:0]  write_reg_m_o;

    typedef struct packed {
        logic [31:0] alu;
        logic        chk_alu;
        logic [31:0] wd;
        logic [4:0]  wr;
        logic [2:0]  ctrl;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_checks = 0, n_fail = 0, last_stall = 0;
    logic        acc = 1'b0;
    logic [31:0] prev_wd = '0;
    logic [63:0] p1, p2;

    execute #(.WIDTH(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .reg_write_e_i(reg_write_e_i), .mem_to_reg_e_i(mem_to_reg_e_i), .mem_write_e_i(mem_write_e_i),
        .alu_control_e_i(alu_control_e_i), .src_a_e_i(src_a_e_i), .src_b_e_i(src_b_e_i),
        .shamt_e_i(shamt_e_i), .write_data_e_i(write_data_e_i), .write_reg_e_i(write_reg_e_i),
        .stall_e_o(stall_e_o), .reg_write_m_o(reg_write_m_o), .mem_to_reg_m_o(mem_to_reg_m_o),
        .mem_write_m_o(mem_write_m_o), .alu_out_m_o(alu_out_m_o), .write_data_m_o(write_data_m_o),
        .write_reg_m_o(write_reg_m_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bubble();
        alu_control_e_i = ALU_ADD;
        src_a_e_i = 32'd1;
        src_b_e_i = 32'd2;
        shamt_e_i = 5'd0;
        write_data_e_i = 32'hDEADBEEF;
        write_reg_e_i = 5'd9;
        {reg_write_e_i, mem_to_reg_e_i, mem_write_e_i} = 3'b000;
    endtask

    task automatic issue(input alu_op_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic [2:0] ctrl, input logic chk_alu,
                         input logic [31:0] exp);
        @(negedge clk_i);
        alu_control_e_i = op;
        src_a_e_i = a;
        src_b_e_i = b;
        shamt_e_i = sh;
        write_data_e_i = a ^ 32'h5A5A5A5A;
        write_reg_e_i = 5'(op) + 5'd1;
        {reg_write_e_i, mem_to_reg_e_i, mem_write_e_i} = ctrl;
        #1;
        last_stall = 0;
        while (stall_e_o && last_stall < 100) begin
            last_stall++;
            @(negedge clk_i);
            #1;
            if (last_stall == 2) begin
                check("bubble_ctrl", 32'({reg_write_m_o, mem_to_reg_m_o, mem_write_m_o}), 32'd0);
                check("hold_wdata", write_data_m_o, prev_wd);
            end
        end
        if (last_stall >= 100) check("stall_timeout", 32'(stall_e_o), 32'd0);
        sb.push_back('{alu: exp, chk_alu: chk_alu, wd: write_data_e_i, wr: write_reg_e_i, ctrl: ctrl});
        prev_wd = write_data_e_i;
        acc = 1'b1;
        @(posedge clk_i);
        #2;
        acc = 1'b0;
        bubble();
    endtask

    always @(posedge clk_i) begin
        if (acc) begin
            #1;
            check("sb_size", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                if (mon_e.chk_alu) check("alu_out", alu_out_m_o, mon_e.alu);
                check("wdata", write_data_m_o, mon_e.wd);
                check("wreg", 32'(write_reg_m_o), 32'(mon_e.wr));
                check("ctrl", 32'({reg_write_m_o, mem_to_reg_m_o, mem_write_m_o}), 32'(mon_e.ctrl));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        alu_op_t     ops[12] = '{ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT,
                                 ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI, ALU_SLT};
        logic [31:0] as[12]  = '{32'd5, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0,
                                 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1};
        logic [31:0] bs[12]  = '{32'd7, 32'h0FF00FF0, 32'h0FF00FF0, 32'h0FF00FF0, 32'h0FF00FF0,
                                 32'd1, 32'd1, 32'd3, 32'h80000000, 32'h80000000, 32'h00001234,
                                 32'hFFFFFFFF};
        logic [4:0]  shs[12] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd4, 5'd31, 5'd4, 5'd0, 5'd0};
        logic [31:0] ex[12]  = '{32'hFFFFFFFE, 32'h00F000F0, 32'hFFF0FFF0, 32'hFF00FF00, 32'h000F000F,
                                 32'd1, 32'd0, 32'h30, 32'd1, 32'hF8000000, 32'h12340000, 32'd0};
        bubble();
        repeat (2) @(negedge clk_i);
        #1;
        check("rst_alu", alu_out_m_o, 32'd0);
        check("rst_ctrl", 32'({reg_write_m_o, mem_to_reg_m_o, mem_write_m_o}), 32'd0);
        check("rst_stall", 32'(stall_e_o), 32'd0);
        rst_i = 1'b1;

        issue(ALU_ADD, 32'h7FFFFFFF, 32'd1, 5'd0, 3'b100, 1'b1, 32'h80000000);
        check("add_stall", last_stall, 32'd0);
        for (int i = 0; i < 12; i++) issue(ops[i], as[i], bs[i], shs[i], 3'(i), 1'b1, ex[i]);

        issue(ALU_MULT, 32'hFFFFFFFD, 32'd5, 5'd0, 3'b000, 1'b0, 32'd0);
        issue(ALU_MFLO, 32'd0, 32'd0, 5'd0, 3'b100, 1'b1, 32'hFFFFFFF1);
        check("mult_stall", last_stall, 32'd33);
        issue(ALU_MFHI, 32'd0, 32'd0, 5'd0, 3'b100, 1'b1, 32'hFFFFFFFF);
        check("mfhi_nostall", last_stall, 32'd0);

        issue(ALU_DIV, 32'hFFFFFFF9, 32'd2, 5'd0, 3'b000, 1'b0, 32'd0);
        issue(ALU_MFLO, 32'd0, 32'd0, 5'd0, 3'b100, 1'b1, 32'hFFFFFFFD);
        check("div_stall", last_stall, 32'd33);
        issue(ALU_MFHI, 32'd0, 32'd0, 5'd0, 3'b100, 1'b1, 32'hFFFFFFFF);
        issue(ALU_DIVU, 32'd7, 32'd0, 5'd0, 3'b000, 1'b0, 32'd0);
        issue(ALU_MFLO, 32'd0, 32'd0, 5'd0, 3'b100, 1'b1, 32'hFFFFFFFF);
        check("div0_stall", last_stall, 32'd33);
        issue(ALU_MFHI, 32'd0, 32'd0, 5'd0, 3'b100, 1'b1, 32'h00000007);
        issue(ALU_DIV, 32'hFFFFFFF9, 32'd0, 5'd0, 3'b000, 1'b0, 32'd0);
        issue(ALU_MFLO, 32'd0, 32'd0, 5'd0, 3'b100, 1'b1, 32'hFFFFFFFF);
        issue(ALU_MFHI, 32'd0, 32'd0, 5'd0, 3'b100, 1'b1, 32'hFFFFFFF9);
        issue(ALU_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd0, 3'b000, 1'b0, 32'd0);
        issue(ALU_MFLO, 32'd0, 32'd0, 5'd0, 3'b100, 1'b1, 32'h80000000);
        issue(ALU_MFHI, 32'd0, 32'd0, 5'd0, 3'b100, 1'b1, 32'h00000000);

        issue(ALU_MTHI, 32'hAAAA5555, 32'd0, 5'd0, 3'b000, 1'b0, 32'd0);
        check("mthi_stall", last_stall, 32'd0);
        issue(ALU_MTLO, 32'h00001234, 32'd0, 5'd0, 3'b000, 1'b0, 32'd0);
        issue(ALU_MFHI, 32'd0, 32'd0, 5'd0, 3'b100, 1'b1, 32'hAAAA5555);
        issue(ALU_MFLO, 32'd0, 32'd0, 5'd0, 3'b100, 1'b1, 32'h00001234);

        p1 = 64'(32'hFFFFFFFF) * 64'(32'hFFFFFFFF);
        p2 = 64'(32'h12345678) * 64'(32'h9ABCDEF0);
        issue(ALU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 3'b000, 1'b0, 32'd0);
        issue(ALU_ADD, 32'd3, 32'd4, 5'd0, 3'b111, 1'b1, 32'd7);
        check("add_busy_stall", last_stall, 32'd0);
        issue(ALU_MULTU, 32'h12345678, 32'h9ABCDEF0, 5'd0, 3'b000, 1'b0, 32'd0);
        check("multu2_stall", last_stall, 32'd32);
        check("multu1_hi", dut.u_md.hi_o, p1[63:32]);
        check("multu1_lo", dut.u_md.lo_o, p1[31:0]);
        issue(ALU_MFLO, 32'd0, 32'd0, 5'd0, 3'b100, 1'b1, p2[31:0]);
        issue(ALU_MFHI, 32'd0, 32'd0, 5'd0, 3'b100, 1'b1, p2[63:32]);

        issue(ALU_MULT, 32'd6, 32'd7, 5'd0, 3'b000, 1'b0, 32'd0);
        repeat (9) @(negedge clk_i);
        alu_control_e_i = ALU_MFLO;
        #1;
        check("busy_stall", 32'(stall_e_o), 32'd1);
        rst_i = 1'b0;
        #1;
        check("arst_stall", 32'(stall_e_o), 32'd0);
        check("arst_alu", alu_out_m_o, 32'd0);
        check("arst_wdata", write_data_m_o, 32'd0);
        check("arst_wreg", 32'(write_reg_m_o), 32'd0);
        check("arst_ctrl", 32'({reg_write_m_o, mem_to_reg_m_o, mem_write_m_o}), 32'd0);
        check("arst_hi", dut.u_md.hi_o, 32'd0);
        check("arst_lo", dut.u_md.lo_o, 32'd0);
        bubble();
        @(negedge clk_i);
        rst_i = 1'b1;
        issue(ALU_MFLO, 32'd0, 32'd0, 5'd0, 3'b100, 1'b1, 32'd0);
        check("post_rst_stall", last_stall, 32'd0);
        issue(ALU_MFHI, 32'd0, 32'd0, 5'd0, 3'b100, 1'b1, 32'd0);

        repeat (2) @(negedge clk_i);
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
